// File: rtl/decodificador_pkg.sv
// Shared widths and one-hot select constants for the 2-to-4 decoder.
package decodificador_pkg;

  localparam int SEL_W = 2;
  localparam int OUT_W = 4;

  localparam logic [OUT_W-1:0] Y0_SEL = 4'b0001;
  localparam logic [OUT_W-1:0] Y1_SEL = 4'b0010;
  localparam logic [OUT_W-1:0] Y2_SEL = 4'b0100;
  localparam logic [OUT_W-1:0] Y3_SEL = 4'b1000;

endpackage

// File: rtl/decodificador_2x4_core.sv
// Purely combinational 2-bit select to 4-bit one-hot decode.
module decodificador_2x4_core
  import decodificador_pkg::*;
(
  input  logic [SEL_W-1:0] sel,
  output logic [OUT_W-1:0] onehot
);

  always_comb begin
    onehot = Y0_SEL;
    case (sel)
      2'b00:   onehot = Y0_SEL;
      2'b01:   onehot = Y1_SEL;
      2'b10:   onehot = Y2_SEL;
      2'b11:   onehot = Y3_SEL;
      default: onehot = Y0_SEL;
    endcase
  end

endmodule

// File: rtl/decodificador_2x4.sv
// Registered 2-to-4 one-hot decoder with optional active-low outputs,
// decode enable and a valid flag that rises on the first registered decode.
module decodificador_2x4
  import decodificador_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic A,
  input  logic B,
  output logic Y0,
  output logic Y1,
  output logic Y2,
  output logic Y3,
  output logic valid
);

  // Reset value means "nothing asserted" in either polarity.
  localparam logic [OUT_W-1:0] RESET_Y = ACTIVE_LOW ? {OUT_W{1'b1}} : {OUT_W{1'b0}};

  logic [SEL_W-1:0] sel;
  logic [OUT_W-1:0] onehot;
  logic [OUT_W-1:0] y_next;
  logic [OUT_W-1:0] y_reg;
  logic             valid_reg;

  assign sel = {A, B};

  decodificador_2x4_core u_core (
    .sel    (sel),
    .onehot (onehot)
  );

  assign y_next = ACTIVE_LOW ? ~onehot : onehot;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_reg     <= RESET_Y;
      valid_reg <= 1'b0;
    end else if (en) begin
      y_reg     <= y_next;
      valid_reg <= 1'b1;
    end
  end

  assign {Y3, Y2, Y1, Y0} = y_reg;
  assign valid            = valid_reg;

endmodule

// File: tb/tb_decodificador_2x4.sv
// Directed bench for decodificador_2x4: active-high and active-low builds
// share one stimulus stream and are checked against hand-computed vectors.
module tb_decodificador_2x4;

  logic clk = 1'b0;
  logic rst, en, A, B;
  logic y0_h, y1_h, y2_h, y3_h, valid_h;
  logic y0_l, y1_l, y2_l, y3_l, valid_l;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  decodificador_2x4 #(.ACTIVE_LOW(1'b0)) dut_h (
    .clk(clk), .rst(rst), .en(en), .A(A), .B(B),
    .Y0(y0_h), .Y1(y1_h), .Y2(y2_h), .Y3(y3_h), .valid(valid_h)
  );

  decodificador_2x4 #(.ACTIVE_LOW(1'b1)) dut_l (
    .clk(clk), .rst(rst), .en(en), .A(A), .B(B),
    .Y0(y0_l), .Y1(y1_l), .Y2(y2_l), .Y3(y3_l), .valid(valid_l)
  );

  task automatic check(input string tag, input logic [4:0] observed, input logic [4:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %b required %b", tag, observed, expected);
    end
  endtask

  // Checks {valid,Y3..Y0} of both builds plus the one-hot property.
  task automatic check_both(input string tag, input logic valid_exp, input logic [3:0] y_exp);
    logic [3:0] yh;
    logic [3:0] yl;
    yh = {y3_h, y2_h, y1_h, y0_h};
    yl = {y3_l, y2_l, y1_l, y0_l};
    check({tag, "_hi"}, {valid_h, yh}, {valid_exp, y_exp});
    check({tag, "_lo"}, {valid_l, yl}, {valid_exp, ~y_exp});
    if (valid_exp) begin
      check({tag, "_onehot"}, {4'b0, $countones(yh) == 1}, 5'b00001);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; A = 1'b1; B = 1'b1;

    // Asynchronous reset before any clock edge
    #1 rst = 1'b1;
    #1 check_both("reset_async", 1'b0, 4'b0000);
    tick();
    tick();
    check_both("reset_held", 1'b0, 4'b0000);

    rst = 1'b0;
    en  = 1'b1;

    // Full sweep
    A = 1'b0; B = 1'b0; tick(); check_both("sweep_00", 1'b1, 4'b0001);
    A = 1'b0; B = 1'b1; tick(); check_both("sweep_01", 1'b1, 4'b0010);
    A = 1'b1; B = 1'b0; tick(); check_both("sweep_10", 1'b1, 4'b0100);
    A = 1'b1; B = 1'b1; tick(); check_both("sweep_11", 1'b1, 4'b1000);

    // Hold with en low
    A = 1'b1; B = 1'b0; tick(); check_both("hold_load", 1'b1, 4'b0100);
    en = 1'b0; A = 1'b0; B = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_both("hold_en0", 1'b1, 4'b0100);
    end
    en = 1'b1; tick(); check_both("hold_resume", 1'b1, 4'b0010);

    // Mid-cycle select toggling must not reach the outputs
    #1 A = 1'b1; B = 1'b0;
    #1 A = 1'b0; B = 1'b0;
    #1 check_both("glitch_mid", 1'b1, 4'b0010);
    A = 1'b1; B = 1'b1;
    #1 check_both("glitch_pre", 1'b1, 4'b0010);
    tick(); check_both("glitch_edge", 1'b1, 4'b1000);

    // Reset mid-run between edges
    #2 rst = 1'b1;
    #1 check_both("reset_mid", 1'b0, 4'b0000);
    #1 rst = 1'b0;
    A = 1'b0; B = 1'b0;
    #1 check_both("reset_released", 1'b0, 4'b0000);
    tick(); check_both("post_reset_00", 1'b1, 4'b0001);

    // Reset while en low: valid must still clear, then hold with en low
    en = 1'b0;
    #1 rst = 1'b1;
    #1 rst = 1'b0;
    A = 1'b1; B = 1'b1;
    tick(); check_both("reset_en0_hold", 1'b0, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
